// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared widths, loader state encoding and bus-ownership codes
package cpu_pkg;

    localparam int ADDR_W = 4;
    localparam int DATA_W = 8;
    localparam int DEPTH  = 16;

    // Deasserted level of every active-low datapath strobe.
    localparam logic STROBE_IDLE = 1'b1;

    typedef enum logic [2:0] {
        LD_IDLE  = 3'd0,
        LD_WAIT  = 3'd1,
        LD_ADDR  = 3'd2,
        LD_DATA  = 3'd3,
        LD_WRITE = 3'd4,
        LD_DONE  = 3'd5
    } loader_state_e;

    typedef enum logic [1:0] {
        BUS_OWNER_NONE   = 2'd0,
        BUS_OWNER_CPU    = 2'd1,
        BUS_OWNER_LOADER = 2'd2
    } bus_owner_e;

endpackage

// File: rtl/program_loader.sv
// rtl/program_loader.sv - streams a program image into the shared RAM while the CPU is held
module program_loader #(
    parameter int ADDR_W = cpu_pkg::ADDR_W,
    parameter int DATA_W = cpu_pkg::DATA_W,
    parameter int DEPTH  = cpu_pkg::DEPTH
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   length,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic [DATA_W-1:0] bus_out,
    output logic              bus_oe,
    output logic              mar_addr_load_n,
    output logic              mar_mem_load_n,
    output logic              ram_load_n,
    output logic              cpu_hold,
    output logic              busy,
    output logic              done
);
    import cpu_pkg::*;

    loader_state_e     state_q, state_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [ADDR_W:0]   len_q, len_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [ADDR_W:0]   count_inc;
    logic [ADDR_W-1:0] wr_addr;

    assign count_inc = count_q + (ADDR_W+1)'(1);
    assign wr_addr   = ADDR_W'(({1'b0, base_q} + count_q) % (ADDR_W+1)'(DEPTH));

    // State and datapath update on the falling edge so everything is settled
    // by the rising edge where the MAR and RAM sample the bus.
    always_ff @(negedge clk) begin
        if (!rst_n) begin
            state_q <= LD_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            LD_IDLE:  if (start && !abort) state_d = (length == '0) ? LD_DONE : LD_WAIT;
            LD_WAIT:  if (in_valid) state_d = LD_ADDR;
            LD_ADDR:  state_d = LD_DATA;
            LD_DATA:  state_d = LD_WRITE;
            LD_WRITE: state_d = (count_inc == len_q) ? LD_DONE : LD_WAIT;
            LD_DONE:  state_d = LD_IDLE;
            default:  state_d = LD_IDLE;
        endcase
        if (abort && state_q != LD_IDLE) state_d = LD_IDLE;
    end

    always_ff @(negedge clk) begin
        if (!rst_n) begin
            base_q  <= '0;
            len_q   <= '0;
            count_q <= '0;
            data_q  <= '0;
        end else begin
            base_q  <= base_d;
            len_q   <= len_d;
            count_q <= count_d;
            data_q  <= data_d;
        end
    end

    always_comb begin
        base_d  = base_q;
        len_d   = len_q;
        count_d = count_q;
        data_d  = data_q;
        case (state_q)
            LD_IDLE: begin
                if (start && !abort) begin
                    base_d  = base_addr;
                    len_d   = length;
                    count_d = '0;
                end
            end
            LD_WAIT:  if (in_valid) data_d = in_data;
            LD_WRITE: count_d = count_inc;
            default: ;
        endcase
    end

    always_comb begin
        in_ready        = 1'b0;
        bus_out         = '0;
        bus_oe          = 1'b0;
        mar_addr_load_n = STROBE_IDLE;
        mar_mem_load_n  = STROBE_IDLE;
        ram_load_n      = STROBE_IDLE;
        cpu_hold        = 1'b0;
        busy            = 1'b0;
        done            = 1'b0;
        case (state_q)
            LD_WAIT: begin
                in_ready = 1'b1;
                cpu_hold = 1'b1;
                busy     = 1'b1;
            end
            LD_ADDR: begin
                bus_oe          = 1'b1;
                bus_out         = {{(DATA_W-ADDR_W){1'b0}}, wr_addr};
                mar_addr_load_n = ~STROBE_IDLE;
                cpu_hold        = 1'b1;
                busy            = 1'b1;
            end
            LD_DATA: begin
                bus_oe         = 1'b1;
                bus_out        = data_q;
                mar_mem_load_n = ~STROBE_IDLE;
                cpu_hold       = 1'b1;
                busy           = 1'b1;
            end
            LD_WRITE: begin
                ram_load_n = ~STROBE_IDLE;
                cpu_hold   = 1'b1;
                busy       = 1'b1;
            end
            LD_DONE: begin
                done     = 1'b1;
                cpu_hold = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_program_loader.sv
// tb/tb_program_loader.sv - directed vector bench for program_loader with a MAR/RAM model
module tb_program_loader;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       abort;
    logic [3:0] base_addr;
    logic [4:0] length;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic [7:0] bus_out;
    logic       bus_oe;
    logic       mar_addr_load_n;
    logic       mar_mem_load_n;
    logic       ram_load_n;
    logic       cpu_hold;
    logic       busy;
    logic       done;

    program_loader dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .start           (start),
        .abort           (abort),
        .base_addr       (base_addr),
        .length          (length),
        .in_valid        (in_valid),
        .in_data         (in_data),
        .in_ready        (in_ready),
        .bus_out         (bus_out),
        .bus_oe          (bus_oe),
        .mar_addr_load_n (mar_addr_load_n),
        .mar_mem_load_n  (mar_mem_load_n),
        .ram_load_n      (ram_load_n),
        .cpu_hold        (cpu_hold),
        .busy            (busy),
        .done            (done)
    );

    always #5 clk = ~clk;

    // Datapath model: MAR address, MAR data and RAM all sample on the rising edge.
    logic [3:0] mar;
    logic [7:0] mdr;
    logic [7:0] ram [16];
    int         wr_count = 0;
    int         strobe_err = 0;
    int         wait_err = 0;

    always @(posedge clk) begin
        if (!mar_addr_load_n) mar <= bus_out[3:0];
        if (!mar_mem_load_n) mdr <= bus_out;
        if (!ram_load_n) begin
            ram[mar] <= mdr;
            wr_count <= wr_count + 1;
        end
        if ((2'(!mar_addr_load_n) + 2'(!mar_mem_load_n) + 2'(!ram_load_n)) > 2'd1) strobe_err <= strobe_err + 1;
        if (bus_oe && mar_addr_load_n && mar_mem_load_n) strobe_err <= strobe_err + 1;
    end

    int passed = 0;
    int total  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h required %0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] outs();
        return {in_ready, bus_oe, mar_addr_load_n, mar_mem_load_n, ram_load_n, cpu_hold, busy, done};
    endfunction

    task automatic run_load(input logic [3:0] b, input logic [4:0] l, input int gap,
                            input logic [7:0] d0, input logic [7:0] st, output int done_cyc);
        int idx;
        int gcnt;
        idx = 0;
        gcnt = 0;
        done_cyc = -1;
        start = 1'b1;
        base_addr = b;
        length = l;
        for (int c = 1; c <= 200; c++) begin
            tick();
            start = (c == 2);
            base_addr = ~b;
            length = 5'd1;
            if (done) begin
                done_cyc = c;
                break;
            end
            if (in_ready) begin
                if (gcnt < gap) begin
                    in_valid = 1'b0;
                    gcnt++;
                    if (!cpu_hold || bus_oe || !mar_addr_load_n || !mar_mem_load_n || !ram_load_n)
                        wait_err++;
                end else begin
                    in_valid = 1'b1;
                    in_data = d0 + 8'(idx) * st;
                    idx++;
                    gcnt = 0;
                end
            end else begin
                in_valid = 1'b0;
            end
        end
        start = 1'b0;
        in_valid = 1'b0;
    endtask

    typedef struct {
        logic [3:0] base;
        logic [4:0] len;
        int         gap;
        logic [7:0] d0;
        logic [7:0] step;
        int         exp_cyc;
    } vec_t;

    vec_t vecs [4];

    initial begin
        int dc;
        int w0;
        int idx;
        int seen;
        int done_seen;
        logic [3:0] a;

        vecs[0] = '{base: 4'd0,  len: 5'd3,  gap: 0, d0: 8'h12, step: 8'h22, exp_cyc: 13};
        vecs[1] = '{base: 4'd14, len: 5'd4,  gap: 0, d0: 8'hA0, step: 8'h01, exp_cyc: 17};
        vecs[2] = '{base: 4'd5,  len: 5'd2,  gap: 5, d0: 8'h3C, step: 8'h11, exp_cyc: 19};
        vecs[3] = '{base: 4'd0,  len: 5'd16, gap: 0, d0: 8'h80, step: 8'h01, exp_cyc: 65};

        rst_n = 1'b0;
        start = 1'b1;
        abort = 1'b1;
        base_addr = 4'd3;
        length = 5'd2;
        in_valid = 1'b0;
        in_data = 8'h00;
        repeat (3) tick();
        check("reset_outputs", 32'(outs()), 32'h38);
        check("reset_bus_out", 32'(bus_out), 32'h0);
        rst_n = 1'b1;
        start = 1'b1;
        abort = 1'b1;
        tick();
        check("abort_beats_start", 32'({busy, in_ready, cpu_hold, done}), 32'h0);
        start = 1'b0;
        abort = 1'b0;
        tick();

        for (int v = 0; v < 4; v++) begin
            w0 = wr_count;
            run_load(vecs[v].base, vecs[v].len, vecs[v].gap, vecs[v].d0, vecs[v].step, dc);
            check($sformatf("v%0d_done_cycle", v), 32'(dc), 32'(vecs[v].exp_cyc));
            check($sformatf("v%0d_write_count", v), 32'(wr_count - w0), 32'(vecs[v].len));
            for (int i = 0; i < int'(vecs[v].len); i++) begin
                a = vecs[v].base + 4'(i);
                check($sformatf("v%0d_ram[%0d]", v, a), 32'(ram[a]), 32'(vecs[v].d0 + 8'(i) * vecs[v].step));
            end
            if (v == 1) begin
                check("wrap_ram15", 32'(ram[15]), 32'hA1);
                check("wrap_ram0", 32'(ram[0]), 32'hA2);
            end
            tick();
            check($sformatf("v%0d_idle_after_done", v), 32'({cpu_hold, busy, done}), 32'h0);
        end
        check("wait_gap_quiet", 32'(wait_err), 32'h0);

        // Abort in the DATA phase of the second byte: first byte kept, second dropped.
        w0 = wr_count;
        start = 1'b1;
        base_addr = 4'd4;
        length = 5'd4;
        idx = 0;
        seen = 0;
        for (int c = 0; c < 50 && seen < 2; c++) begin
            tick();
            start = 1'b0;
            if (!mar_mem_load_n) seen++;
            if (seen == 2) abort = 1'b1;
            else if (in_ready) begin
                in_valid = 1'b1;
                in_data = 8'hC0 + 8'(idx);
                idx++;
            end else in_valid = 1'b0;
        end
        check("abort_reached_data2", 32'(seen), 32'd2);
        in_valid = 1'b0;
        tick();
        abort = 1'b0;
        check("abort_outputs", 32'(outs()), 32'h38);
        done_seen = 0;
        repeat (6) begin
            tick();
            if (done || busy) done_seen++;
        end
        check("abort_no_done", 32'(done_seen), 32'h0);
        check("abort_ram4", 32'(ram[4]), 32'hC0);
        check("abort_ram5", 32'(ram[5]), 32'h85);
        check("abort_writes", 32'(wr_count - w0), 32'd1);

        // Zero-length load: a single done pulse, no writes.
        w0 = wr_count;
        start = 1'b1;
        base_addr = 4'd7;
        length = 5'd0;
        tick();
        start = 1'b0;
        check("len0_done", 32'({done, busy, cpu_hold, in_ready}), 32'b1010);
        tick();
        check("len0_after", 32'({done, cpu_hold}), 32'h0);
        check("len0_writes", 32'(wr_count - w0), 32'd0);

        // Reset during the DATA phase, then a clean load from count 0.
        start = 1'b1;
        base_addr = 4'd8;
        length = 5'd2;
        seen = 0;
        for (int c = 0; c < 50 && seen == 0; c++) begin
            tick();
            start = 1'b0;
            if (!mar_mem_load_n) begin
                seen = 1;
                rst_n = 1'b0;
                in_valid = 1'b0;
            end else if (in_ready) begin
                in_valid = 1'b1;
                in_data = 8'h5A;
            end else in_valid = 1'b0;
        end
        tick();
        check("midload_reset_outputs", 32'(outs()), 32'h38);
        rst_n = 1'b1;
        tick();
        w0 = wr_count;
        run_load(4'd8, 5'd2, 0, 8'hD0, 8'h01, dc);
        check("post_reset_done_cycle", 32'(dc), 32'd9);
        check("post_reset_ram8", 32'(ram[8]), 32'hD0);
        check("post_reset_ram9", 32'(ram[9]), 32'hD1);
        check("post_reset_writes", 32'(wr_count - w0), 32'd2);
        tick();
        check("one_hot_strobes", 32'(strobe_err), 32'h0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
